// File: rtl/sift_pkg.sv
// sift_pkg: shared types and helpers for the SIFT pipeline blocks.
//   dog_writer_state_t : sequencing states of the DoG writer
//   dog_width()        : signed DoG sample width for a given pixel depth
package sift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } dog_writer_state_t;

    // A difference of two unsigned N-bit pixels needs N+1 signed bits.
    function automatic int unsigned dog_width(input int unsigned bit_depth);
        return bit_depth + 1;
    endfunction

endpackage

// File: rtl/bram_read_pipe.sv
// bram_read_pipe: LATENCY-deep shift register of {valid, address} that keeps
// each issued BRAM read address aligned with the data it returns.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : an address is being issued this cycle
//   in_addr    : the issued address
//   out_valid  : data for out_addr is present on the BRAM outputs this cycle
//   out_addr   : address matching the current BRAM data
//   active     : any read still in flight
module bram_read_pipe #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              active
);

    logic [LATENCY-1:0] vld;
    logic [ADDR_W-1:0]  adr [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                adr[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
            end
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_addr  = adr[LATENCY-1];
    assign active    = |vld;

endmodule

// File: rtl/dog_writer.sv
// dog_writer: streams two blurred images out of their BRAMs at one pixel per
// cycle and writes the signed per-pixel difference (hi - lo) into the DoG BRAM.
//   clk, rst_in          : clock, asynchronous active-high reset
//   enable               : start request, honoured only while idle
//   src_address          : read address to both source BRAMs
//   lo_data, hi_data     : unsigned pixels from the lower/higher-sigma images
//   dog_address, dog_data: DoG BRAM write port (dog_data signed, BIT_DEPTH+1)
//   dog_we               : DoG BRAM write enable
//   busy                 : high from start until done
//   done_writing         : one-cycle pulse after the last write
// Build option: define DOG_CONTRAST_ZERO_EN to write 0 for any difference whose
// magnitude is below CONTRAST_THRESHOLD.
module dog_writer
    import sift_pkg::*;
#(
    parameter int unsigned BIT_DEPTH          = 8,
    parameter int unsigned DIMENSION          = 4,
    parameter int unsigned READ_LATENCY       = 2,
    parameter int unsigned CONTRAST_THRESHOLD = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_in,
    input  logic                                      enable,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0]    src_address,
    input  logic [BIT_DEPTH-1:0]                      lo_data,
    input  logic [BIT_DEPTH-1:0]                      hi_data,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0]    dog_address,
    output logic [BIT_DEPTH:0]                        dog_data,
    output logic                                      dog_we,
    output logic                                      busy,
    output logic                                      done_writing
);

    localparam int unsigned N  = DIMENSION * DIMENSION;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned DW = dog_width(BIT_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    dog_writer_state_t state;

    logic          pipe_valid;
    logic [AW-1:0] pipe_addr;
    logic          pipe_active;
    logic [DW-1:0] diff_raw;
    logic [DW-1:0] wr_data;

    bram_read_pipe #(
        .LATENCY (READ_LATENCY),
        .ADDR_W  (AW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst_in),
        .in_valid  (state == READ),
        .in_addr   (src_address),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr),
        .active    (pipe_active)
    );

`ifdef DOG_CONTRAST_ZERO_EN
    logic [DW-1:0] diff_mag;
`endif

    always_comb begin
        diff_raw = DW'(hi_data) - DW'(lo_data);
        wr_data  = diff_raw;
`ifdef DOG_CONTRAST_ZERO_EN
        diff_mag = diff_raw[DW-1] ? (~diff_raw + DW'(1)) : diff_raw;
        if (diff_mag < DW'(CONTRAST_THRESHOLD)) begin
            wr_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            src_address  <= '0;
            dog_address  <= '0;
            dog_data     <= '0;
            dog_we       <= 1'b0;
            busy         <= 1'b0;
            done_writing <= 1'b0;
        end else begin
            // Write register: one cycle behind the data/address alignment.
            dog_we <= pipe_valid;
            if (pipe_valid) begin
                dog_address <= pipe_addr;
                dog_data    <= wr_data;
            end

            done_writing <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= READ;
                        busy        <= 1'b1;
                        src_address <= '0;
                    end
                end
                READ: begin
                    if (src_address == LAST_ADDR) begin
                        state <= DRAIN;
                    end else begin
                        src_address <= src_address + AW'(1);
                    end
                end
                DRAIN: begin
                    // Pipe empties on the same edge the last write registers,
                    // so done lands exactly one edge after that write.
                    if (!pipe_active) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        done_writing <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dog_writer.sv
// tb_dog_writer: randomized self-checking bench for dog_writer. Two instances
// (read latency 2 and 1) are fed by behavioural BRAMs; every observed write,
// done pulse and busy fall is logged with its edge number and compared with
// expectations derived from the pixel-difference rule and the edge timing.
module tb_dog_writer;

    localparam int N = 16;

    typedef struct {
        int         cyc;
        int         addr;
        logic [8:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_in = 1'b1;
    logic en0 = 1'b0, en1 = 1'b0;

    logic [3:0] src0, src1, daddr0, daddr1;
    logic [7:0] lo0, hi0, lo1, hi1;
    logic [8:0] data0, data1;
    logic       we0, we1, busy0, busy1, done0, done1;

    logic [7:0] lo_mem [N];
    logic [7:0] hi_mem [N];
    logic [7:0] lo0_a, lo0_b, hi0_a, hi0_b, lo1_a, hi1_a;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t wq [2][$];
    int  dq [2][$];
    int  bq [2][$];
    logic pb0 = 1'b0, pb1 = 1'b0;

    always #5 clk = ~clk;

    dog_writer #(
        .BIT_DEPTH(8), .DIMENSION(4), .READ_LATENCY(2), .CONTRAST_THRESHOLD(4)
    ) dut0 (
        .clk(clk), .rst_in(rst_in), .enable(en0), .src_address(src0),
        .lo_data(lo0), .hi_data(hi0), .dog_address(daddr0), .dog_data(data0),
        .dog_we(we0), .busy(busy0), .done_writing(done0)
    );

    dog_writer #(
        .BIT_DEPTH(8), .DIMENSION(4), .READ_LATENCY(1), .CONTRAST_THRESHOLD(4)
    ) dut1 (
        .clk(clk), .rst_in(rst_in), .enable(en1), .src_address(src1),
        .lo_data(lo1), .hi_data(hi1), .dog_address(daddr1), .dog_data(data1),
        .dog_we(we1), .busy(busy1), .done_writing(done1)
    );

    // Behavioural synchronous-read BRAMs with latency 2 and 1.
    always @(posedge clk) begin
        lo0_a <= lo_mem[src0]; lo0_b <= lo0_a;
        hi0_a <= hi_mem[src0]; hi0_b <= hi0_a;
        lo1_a <= lo_mem[src1];
        hi1_a <= hi_mem[src1];
    end
    assign lo0 = lo0_b;
    assign hi0 = hi0_b;
    assign lo1 = lo1_a;
    assign hi1 = hi1_a;

    // Edge counter and event log, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (we0) wq[0].push_back('{cyc, int'(daddr0), data0});
        if (we1) wq[1].push_back('{cyc, int'(daddr1), data1});
        if (done0) dq[0].push_back(cyc);
        if (done1) dq[1].push_back(cyc);
        if (pb0 && !busy0) bq[0].push_back(cyc);
        if (pb1 && !busy1) bq[1].push_back(cyc);
        pb0 = busy0;
        pb1 = busy1;
    end

    // Reference: signed difference hi - lo, optionally zeroed below threshold 4.
    function automatic logic [8:0] ref_dog(input int hi, input int lo);
        int d;
        d = hi - lo;
`ifdef DOG_CONTRAST_ZERO_EN
        if (d < 4 && d > -4) d = 0;
`endif
        return 9'(d);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            lo_mem[i] = 8'($urandom_range(0, 255));
            hi_mem[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic clear_logs();
        for (int w = 0; w < 2; w++) begin
            wq[w].delete();
            dq[w].delete();
            bq[w].delete();
        end
    endtask

    task automatic set_en(input int which, input logic v);
        if (which == 0) en0 = v;
        else en1 = v;
    endtask

    // Start one run on instance 'which', optionally pulsing enable at E+4 and
    // E+10, wait (bounded) for completion, then check the logged events.
    task automatic exercise_run(input int which, input int lat, input bit extra);
        int   e;
        logic b;
        clear_logs();
        @(negedge clk);
        set_en(which, 1'b1);
        e = cyc + 1;
        @(negedge clk);
        set_en(which, 1'b0);
        b = (which == 0) ? busy0 : busy1;
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start inst%0d: got %b want 1", which, b);
        end
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            set_en(which, extra && (cyc == e + 3 || cyc == e + 9));
            if (dq[which].size() > 0 && cyc >= dq[which][0] + 4) break;
        end
        set_en(which, 1'b0);

        checks++;
        if (wq[which].size() != N) begin
            errors++;
            $display("FAIL write_count inst%0d: got %0d want %0d", which, wq[which].size(), N);
        end
        for (int i = 0; i < N && i < wq[which].size(); i++) begin
            checks++;
            if (wq[which][i].addr != i) begin
                errors++;
                $display("FAIL write_addr inst%0d idx%0d: got %0d want %0d", which, i, wq[which][i].addr, i);
            end
            checks++;
            if (wq[which][i].cyc != e + i + lat + 1) begin
                errors++;
                $display("FAIL write_edge inst%0d idx%0d: got E+%0d want E+%0d", which, i,
                         wq[which][i].cyc - e, i + lat + 1);
            end
            checks++;
            if (wq[which][i].data !== ref_dog(int'(hi_mem[i]), int'(lo_mem[i]))) begin
                errors++;
                $display("FAIL write_data inst%0d addr%0d: got %h want %h", which, i,
                         wq[which][i].data, ref_dog(int'(hi_mem[i]), int'(lo_mem[i])));
            end
        end
        checks++;
        if (dq[which].size() != 1) begin
            errors++;
            $display("FAIL done_count inst%0d: got %0d want 1", which, dq[which].size());
        end else begin
            checks++;
            if (dq[which][0] != e + N + lat + 1) begin
                errors++;
                $display("FAIL done_edge inst%0d: got E+%0d want E+%0d", which, dq[which][0] - e, N + lat + 1);
            end
        end
        checks++;
        if (bq[which].size() != 1 || bq[which][0] != e + N + lat + 1) begin
            errors++;
            $display("FAIL busy_fall inst%0d: got %0d falls first E+%0d want one at E+%0d", which,
                     bq[which].size(), (bq[which].size() > 0) ? bq[which][0] - e : -1, N + lat + 1);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({src0, daddr0, data0, we0, busy0, done0} !== '0) begin
            errors++;
            $display("FAIL reset_inst0: got src=%h addr=%h data=%h we=%b busy=%b done=%b want all 0",
                     src0, daddr0, data0, we0, busy0, done0);
        end
        checks++;
        if ({src1, daddr1, data1, we1, busy1, done1} !== '0) begin
            errors++;
            $display("FAIL reset_inst1: got src=%h addr=%h data=%h we=%b busy=%b done=%b want all 0",
                     src1, daddr1, data1, we1, busy1, done1);
        end
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_uniform();
        for (int i = 0; i < N; i++) begin
            lo_mem[i] = 8'd10;
            hi_mem[i] = 8'd30;
        end
        exercise_run(0, 2, 1'b0);
        checks++;
        if (wq[0].size() > 0 && wq[0][N/2 < wq[0].size() ? N/2 : 0].data !== 9'h014) begin
            errors++;
            $display("FAIL uniform_value: got %h want 014", wq[0][0].data);
        end
    endtask

    task automatic test_extremes();
        fill_random();
        lo_mem[5] = 8'd255; hi_mem[5] = 8'd0;
        lo_mem[6] = 8'd0;   hi_mem[6] = 8'd255;
        lo_mem[7] = 8'd128; hi_mem[7] = 8'd128;
        exercise_run(0, 2, 1'b0);
        if (wq[0].size() == N) begin
            checks++;
            if (wq[0][5].data !== 9'h101) begin
                errors++;
                $display("FAIL extreme_neg255: got %h want 101", wq[0][5].data);
            end
            checks++;
            if (wq[0][6].data !== 9'h0FF) begin
                errors++;
                $display("FAIL extreme_pos255: got %h want 0ff", wq[0][6].data);
            end
            checks++;
            if (wq[0][7].data !== 9'h000) begin
                errors++;
                $display("FAIL extreme_equal: got %h want 000", wq[0][7].data);
            end
        end
    endtask

    task automatic test_enable_while_busy();
        fill_random();
        exercise_run(0, 2, 1'b1);
        repeat (6) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || wq[0].size() != N) begin
            errors++;
            $display("FAIL no_restart: got busy=%b writes=%0d want busy=0 writes=%0d", busy0, wq[0].size(), N);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        fill_random();
        clear_logs();
        @(negedge clk);
        en0 = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        n = 0;
        while (!(wq[0].size() > 0 && wq[0][wq[0].size()-1].addr == 7) && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL midreset_reach_addr7: got timeout want write of address 7");
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if (we0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got we=%b busy=%b want 0 0", we0, busy0);
        end
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (dq[0].size() != 0 || wq[0].size() != 8) begin
            errors++;
            $display("FAIL midreset_quiet: got done=%0d writes=%0d want done=0 writes=8", dq[0].size(), wq[0].size());
        end
        fill_random();
        exercise_run(0, 2, 1'b0);
    endtask

    task automatic test_contrast();
        fill_random();
        lo_mem[0] = 8'd100; hi_mem[0] = 8'd103;
        lo_mem[1] = 8'd103; hi_mem[1] = 8'd100;
        lo_mem[2] = 8'd100; hi_mem[2] = 8'd104;
        lo_mem[3] = 8'd104; hi_mem[3] = 8'd100;
        exercise_run(0, 2, 1'b0);
        if (wq[0].size() == N) begin
`ifdef DOG_CONTRAST_ZERO_EN
            checks++;
            if (wq[0][0].data !== 9'h000 || wq[0][1].data !== 9'h000) begin
                errors++;
                $display("FAIL contrast_small: got %h %h want 000 000", wq[0][0].data, wq[0][1].data);
            end
`else
            checks++;
            if (wq[0][0].data !== 9'h003 || wq[0][1].data !== 9'h1FD) begin
                errors++;
                $display("FAIL contrast_raw: got %h %h want 003 1fd", wq[0][0].data, wq[0][1].data);
            end
`endif
            checks++;
            if (wq[0][2].data !== 9'h004 || wq[0][3].data !== 9'h1FC) begin
                errors++;
                $display("FAIL contrast_edge: got %h %h want 004 1fc", wq[0][2].data, wq[0][3].data);
            end
        end
    endtask

    task automatic test_latency1();
        fill_random();
        exercise_run(1, 1, 1'b0);
        fill_random();
        exercise_run(1, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_extremes();
        test_enable_while_busy();
        test_mid_reset();
        test_contrast();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dog_writer.md
Name: dog_writer

Overview:
- Builds one Difference-of-Gaussian image for the extrema stage.
- Streams two blurred 8-bit greyscale images from their BRAMs and computes a signed per-pixel difference.
- Writes the difference into the DoG BRAM that the extrema checker later reads.
- Fully pipelined at one pixel per cycle, with a start/done handshake to the octave controller.

Parameters:
- BIT_DEPTH, 8: unsigned input pixel width; DoG output width is BIT_DEPTH+1, signed.
- DIMENSION, 4: image side length; N = DIMENSION*DIMENSION pixels.
- READ_LATENCY, 2: source BRAM read latency in cycles (legal 1..3).
- CONTRAST_THRESHOLD, 4: magnitude threshold; used only under DOG_CONTRAST_ZERO_EN.

Ports:
- clk  in  1  system clock
- rst_in  in  1  reset; asynchronous, active-high
- enable  in  1  start request, sampled in IDLE only
- src_address  out  $clog2(N)  read address driven to both source BRAMs
- lo_data  in  BIT_DEPTH  unsigned pixel from the lower-sigma image
- hi_data  in  BIT_DEPTH  unsigned pixel from the higher-sigma image
- dog_address  out  $clog2(N)  DoG BRAM write address
- dog_data  out  BIT_DEPTH+1  signed difference
- dog_we  out  1  DoG BRAM write enable
- busy  out  1  high from start until done
- done_writing  out  1  one-cycle pulse after the last write

Behaviour:
- Clock and reset: one clock, clk. Reset rst_in is asynchronous and active-high.
- Reset values: src_address=0, dog_address=0, dog_data=0, dog_we=0, busy=0, done_writing=0, state=IDLE, delay line cleared.
- Reset mid-operation: the block returns to IDLE immediately. No further writes occur and no done pulse is issued. The next enable restarts from address 0.
- Arithmetic:
  - dog_data = zero-extend(hi_data) - zero-extend(lo_data), both extended to BIT_DEPTH+1 bits. The result is two's complement.
  - Range is -255..+255. No overflow is possible.
- States:
  - IDLE: if enable is high at an edge E, move to READ with busy=1 and src_address=0.
  - READ: src_address increments by 1 each cycle. After N-1 is driven, move to DRAIN.
  - DRAIN: wait until the delay line is empty. Then pulse done_writing for one cycle, set busy=0 and return to IDLE.
- Delay line: a READ_LATENCY-deep shift register of {valid, address} aligns each issued address with its returning data.
- Write register: a write for address k is registered one cycle after its data is valid.
  - dog_we=1 and dog_address=k at edge E+k+READ_LATENCY+1.
- Throughput and timing:
  - Exactly N writes per run, on consecutive cycles, with addresses 0..N-1 in order.
  - The last write is at edge E+N+READ_LATENCY.
  - done_writing and busy falling happen at edge E+N+READ_LATENCY+1.
- enable while busy: ignored; it is not queued.
- enable held high through done: a new run starts on the first IDLE cycle.
- dog_we=0 outside valid write cycles. dog_data holds its last value when dog_we is low.

Optional Feature:
- Macro: DOG_CONTRAST_ZERO_EN.
- Defined: when |difference| < CONTRAST_THRESHOLD, dog_data is written as 0. The threshold compare is combinational, ahead of the write register, and adds no latency. This suppresses low-contrast extrema, because strict comparisons downstream reject ties.
- Undefined: the raw difference is always written, and CONTRAST_THRESHOLD is unused.

Decomposition:
- Package sift_pkg holds:
  - typedef dog_writer_state_t {IDLE, READ, DRAIN}
  - function dog_width(bit_depth) returning bit_depth+1
- Sub-module bram_read_pipe (parameters LATENCY and ADDR_W) holds the valid/address delay line with async reset. The parent holds the FSM, subtraction, threshold and write register.

Test Plan:
- Uniform difference: lo=10 and hi=30 everywhere, DIMENSION=4, READ_LATENCY=2.
  - Expect 16 writes of dog_data=9'h014, addresses 0..15 on consecutive cycles.
  - First dog_we at edge E+3, done_writing at E+19, busy low at E+19.
- Extreme values:
  - lo=255, hi=0 at address 5 → dog_data=9'h101 (-255).
  - lo=0, hi=255 at address 6 → 9'h0FF.
  - lo=hi=128 at address 7 → 9'h000.
- enable pulses during busy at cycles E+4 and E+10 → still exactly 16 writes and one done pulse; no restart.
- Reset mid-run: assert rst_in asynchronously just after the address-7 write → dog_we and busy drop without waiting for a clock edge, and no done pulse occurs. A later enable produces a clean 16-write run from address 0.
- Compiled with DOG_CONTRAST_ZERO_EN and threshold 4:
  - diffs +3 → 0, -3 → 0, +4 → 9'h004, -4 → 9'h1FC.
  - Without the macro, +3 → 9'h003.
- READ_LATENCY=1 → first dog_we at E+2 and done_writing at E+18; data still correctly aligned with addresses.
